// File: rtl/excesso_3_serial_if.sv
// Handshake bundle for the digit-serial BCD <-> excess-3 converter.
// The master side presents words and takes results; the slave side is the converter.
interface excesso_3_serial_if #(
    parameter int DIGITS = 4
);
    localparam int W = 4 * DIGITS;

    logic              in_valid;
    logic              in_ready;
    logic              mode;
    logic [W-1:0]      data_in;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      data_out;
    logic              err;
    logic [DIGITS-1:0] err_mask;

    modport master (
        output in_valid,
        input  in_ready,
        output mode,
        output data_in,
        input  out_valid,
        output out_ready,
        input  data_out,
        input  err,
        input  err_mask
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  mode,
        input  data_in,
        output out_valid,
        input  out_ready,
        output data_out,
        output err,
        output err_mask
    );
endinterface

// File: rtl/excesso_3_serial.sv
// Digit-serial converter between packed BCD 8421 and excess-3 words.
// One digit per clock, least-significant first; invalid digits become 4'hF
// and are flagged per position without stopping the conversion.
module excesso_3_serial #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    excesso_3_serial_if.slave   bus
);
    localparam int W  = 4 * DIGITS;
    localparam int IW = $clog2(DIGITS + 1);
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [IW-1:0]     idx;
    logic [W-1:0]      word;
    logic              mode_q;
    logic [W-1:0]      data_out_q;
    logic [DIGITS-1:0] err_mask_q;
    logic [3:0]        digit;
    logic [3:0]        result;
    logic              bad;
    logic              accept;

    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = (state == DONE);
    assign bus.data_out  = data_out_q;
    assign bus.err_mask  = err_mask_q;
    assign bus.err       = |err_mask_q;
    assign accept        = bus.in_valid && bus.in_ready;

    // Convert the digit currently selected by idx; out-of-range codes map to 4'hF.
    always_comb begin
        digit  = 4'(word >> (4 * idx));
        result = 4'hF;
        bad    = 1'b1;
        if (!mode_q) begin
            if (digit <= 4'd9) begin
                result = digit + 4'd3;
                bad    = 1'b0;
            end
        end else begin
            if ((digit >= 4'd3) && (digit <= 4'd12)) begin
                result = digit - 4'd3;
                bad    = 1'b0;
            end
        end
    end

    // Next-state logic: accept in IDLE, walk the digits in CONV, hold results in DONE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = CONV;
            CONV: if (idx == LAST) state_next = DONE;
            DONE: if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register; reset abandons any word in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath: capture the word on accept, then OR one converted digit per cycle into the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= '0;
            word       <= '0;
            mode_q     <= 1'b0;
            data_out_q <= '0;
            err_mask_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        word       <= bus.data_in;
                        mode_q     <= bus.mode;
                        data_out_q <= '0;
                        err_mask_q <= '0;
                        idx        <= '0;
                    end
                end
                CONV: begin
                    data_out_q <= data_out_q | (W'(result) << (4 * idx));
                    err_mask_q <= err_mask_q | (DIGITS'(bad) << idx);
                    idx        <= idx + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_excesso_3_serial.sv
// Self-checking bench for excesso_3_serial: a 4-digit instance for word-level
// vectors and corner sequences, and a 1-digit instance for the single-digit sweep.
module tb_excesso_3_serial;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    excesso_3_serial_if #(.DIGITS(4)) bus4 ();
    excesso_3_serial_if #(.DIGITS(1)) bus1 ();

    excesso_3_serial #(.DIGITS(4)) u4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    excesso_3_serial #(.DIGITS(1)) u1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    typedef struct {
        logic        mode;
        logic [15:0] data;
        logic [15:0] expData;
        logic [3:0]  expMask;
    } vec_t;

    vec_t vecs[7];
    int   assertions = 0;
    int   failures   = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic setInputs(input int sel, input logic v, input logic m, input logic [15:0] d, input logic rdy);
        if (sel == 4) begin
            bus4.in_valid  = v;
            bus4.mode      = m;
            bus4.data_in   = d;
            bus4.out_ready = rdy;
        end else begin
            bus1.in_valid  = v;
            bus1.mode      = m;
            bus1.data_in   = d[3:0];
            bus1.out_ready = rdy;
        end
    endtask

    task automatic sampleOut(input int sel, output logic iRdy, output logic oVld,
                             output logic [15:0] dout, output logic [3:0] mask, output logic e);
        if (sel == 4) begin
            iRdy = bus4.in_ready;
            oVld = bus4.out_valid;
            dout = bus4.data_out;
            mask = bus4.err_mask;
            e    = bus4.err;
        end else begin
            iRdy = bus1.in_ready;
            oVld = bus1.out_valid;
            dout = {12'h000, bus1.data_out};
            mask = {3'b000, bus1.err_mask};
            e    = bus1.err;
        end
    endtask

    task automatic waitResult(input int sel, input string name, input int expCycles);
        logic iRdy, oVld, e;
        logic [15:0] dout;
        logic [3:0] mask;
        int cycles = 0;
        sampleOut(sel, iRdy, oVld, dout, mask, e);
        while (!oVld && cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
            sampleOut(sel, iRdy, oVld, dout, mask, e);
        end
        checkOutput({name, " latency"}, 64'(cycles), 64'(expCycles));
    endtask

    task automatic applyStimulus(input int sel, input string name, input logic m, input logic [15:0] d,
                                 input logic [15:0] expD, input logic [3:0] expM, input int digits);
        logic iRdy, oVld, e;
        logic [15:0] dout;
        logic [3:0] mask;
        int guard = 0;
        @(negedge clk);
        setInputs(sel, 1'b1, m, d, 1'b1);
        sampleOut(sel, iRdy, oVld, dout, mask, e);
        while (!iRdy && guard < 40) begin
            @(negedge clk);
            guard++;
            sampleOut(sel, iRdy, oVld, dout, mask, e);
        end
        checkOutput({name, " in_ready"}, 64'(iRdy), 64'd1);
        @(posedge clk); #1;
        setInputs(sel, 1'b0, 1'b0, 16'h0000, 1'b1);
        waitResult(sel, name, digits);
        sampleOut(sel, iRdy, oVld, dout, mask, e);
        checkOutput({name, " data_out"}, 64'(dout), 64'(expD));
        checkOutput({name, " err_mask"}, 64'(mask), 64'(expM));
        checkOutput({name, " err"}, 64'(e), 64'(expM != 4'h0));
        @(posedge clk); #1;
        sampleOut(sel, iRdy, oVld, dout, mask, e);
        checkOutput({name, " back to idle"}, 64'({oVld, iRdy}), 64'(2'b01));
    endtask

    initial begin
        logic iRdy, oVld, e;
        logic [15:0] dout;
        logic [3:0] mask;
        logic seen;
        logic [51:0] exp0;
        logic [51:0] exp1;
        logic [12:0] bad0;
        logic [12:0] bad1;

        vecs[0] = '{1'b0, 16'h1234, 16'h4567, 4'b0000};
        vecs[1] = '{1'b1, 16'h4567, 16'h1234, 4'b0000};
        vecs[2] = '{1'b1, 16'h3C3C, 16'h0909, 4'b0000};
        vecs[3] = '{1'b0, 16'h12A9, 16'h45FC, 4'b0010};
        vecs[4] = '{1'b1, 16'h2D45, 16'hFF12, 4'b1100};
        vecs[5] = '{1'b0, 16'h9999, 16'hCCCC, 4'b0000};
        vecs[6] = '{1'b1, 16'h0000, 16'hFFFF, 4'b1111};

        // Single-digit results for digits 0..C, digit 0 in the low nibble.
        exp0 = 52'hFFFCBA9876543;
        exp1 = 52'h9876543210FFF;
        bad0 = 13'h1C00;
        bad1 = 13'h0007;

        // Reset held two cycles with in_valid asserted.
        rst = 1'b1;
        setInputs(4, 1'b1, 1'b0, 16'h1234, 1'b1);
        setInputs(1, 1'b1, 1'b0, 16'h0005, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            sampleOut(4, iRdy, oVld, dout, mask, e);
            checkOutput($sformatf("reset%0d ready/valid", i), 64'({iRdy, oVld}), 64'(2'b00));
            checkOutput($sformatf("reset%0d data_out", i), 64'(dout), 64'h0);
            checkOutput($sformatf("reset%0d err_mask", i), 64'(mask), 64'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        setInputs(4, 1'b0, 1'b0, 16'h0000, 1'b1);
        setInputs(1, 1'b0, 1'b0, 16'h0000, 1'b1);
        #1;
        sampleOut(4, iRdy, oVld, dout, mask, e);
        checkOutput("after reset in_ready", 64'(iRdy), 64'd1);

        // Table-driven word vectors.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(4, $sformatf("vec%0d", i), vecs[i].mode, vecs[i].data,
                          vecs[i].expData, vecs[i].expMask, 4);
        end

        // Backpressure: result must hold and a pending word must wait for IDLE.
        @(negedge clk);
        setInputs(4, 1'b1, 1'b0, 16'h1234, 1'b0);
        @(posedge clk); #1;
        setInputs(4, 1'b0, 1'b0, 16'h0000, 1'b0);
        waitResult(4, "bp first", 4);
        setInputs(4, 1'b1, 1'b1, 16'h0000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            sampleOut(4, iRdy, oVld, dout, mask, e);
            checkOutput($sformatf("bp hold%0d data_out", i), 64'(dout), 64'h4567);
            checkOutput($sformatf("bp hold%0d valid/ready", i), 64'({oVld, iRdy}), 64'(2'b10));
        end
        setInputs(4, 1'b1, 1'b1, 16'h0000, 1'b1);
        @(posedge clk); #1;
        sampleOut(4, iRdy, oVld, dout, mask, e);
        checkOutput("bp idle valid/ready", 64'({oVld, iRdy}), 64'(2'b01));
        @(posedge clk); #1;
        sampleOut(4, iRdy, oVld, dout, mask, e);
        checkOutput("bp accepted valid/ready", 64'({oVld, iRdy}), 64'(2'b00));
        setInputs(4, 1'b0, 1'b0, 16'h0000, 1'b1);
        waitResult(4, "bp second", 4);
        sampleOut(4, iRdy, oVld, dout, mask, e);
        checkOutput("bp second data_out", 64'(dout), 64'hFFFF);
        checkOutput("bp second err_mask", 64'(mask), 64'hF);
        @(posedge clk); #1;

        // Reset on the second CONV edge abandons the word.
        @(negedge clk);
        setInputs(4, 1'b1, 1'b0, 16'h1234, 1'b1);
        @(posedge clk); #1;
        setInputs(4, 1'b0, 1'b0, 16'h0000, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        sampleOut(4, iRdy, oVld, dout, mask, e);
        checkOutput("midreset data_out", 64'(dout), 64'h0);
        checkOutput("midreset err_mask", 64'(mask), 64'h0);
        checkOutput("midreset valid/ready", 64'({oVld, iRdy}), 64'(2'b00));
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            sampleOut(4, iRdy, oVld, dout, mask, e);
            if (oVld) seen = 1'b1;
        end
        checkOutput("midreset no out_valid", 64'(seen), 64'd0);
        checkOutput("midreset idle ready", 64'(iRdy), 64'd1);
        applyStimulus(4, "post reset", 1'b0, 16'h0987, 16'h3CBA, 4'b0000, 4);

        // Single-digit sweep on the 1-digit instance, both directions.
        for (int d = 0; d < 13; d++) begin
            applyStimulus(1, $sformatf("d1 m0 digit%0h", d), 1'b0, 16'(d),
                          {12'h000, exp0[4*d +: 4]}, {3'b000, bad0[d]}, 1);
            applyStimulus(1, $sformatf("d1 m1 digit%0h", d), 1'b1, 16'(d),
                          {12'h000, exp1[4*d +: 4]}, {3'b000, bad1[d]}, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end
endmodule
